gcd_sequencer: RTL and testbench

Host-side initiator for the GCD core (controller plus datapath). Accepts operand pairs over a valid/ready request channel, drives the core's clear, operand and stop handshake, captures the result and returns it over a valid/ready response channel. Trivial operand pairs are answered directly, so the core is never started on inputs it cannot terminate on. Sits between the bus/test front end and the GCD core.

---
 rtl/gcd_pkg.sv | 16 +
 rtl/gcd_seq_watchdog.sv | 28 ++
 rtl/gcd_sequencer.sv | 127 ++++++++++++
 tb/tb_gcd_sequencer.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/gcd_pkg.sv
// Shared definitions for the GCD sequencer: state encodings and parameter defaults.
package gcd_pkg;

  localparam int unsigned GCD_WIDTH      = 8;
  localparam int unsigned GCD_CLR_CYCLES = 2;
  localparam int unsigned GCD_MAX_CYCLES = 1024;

  typedef enum logic [2:0] {
    ST_INIT = 3'd0,
    ST_IDLE = 3'd1,
    ST_LOAD = 3'd2,
    ST_RUN  = 3'd3,
    ST_RESP = 3'd4
  } gcd_state_t;

endpackage

// File: rtl/gcd_seq_watchdog.sv
// RUN-phase cycle counter for the GCD sequencer; flags expiry after MAX_CYCLES RUN cycles.
module gcd_seq_watchdog
  import gcd_pkg::*;
#(
  parameter int unsigned MAX_CYCLES = GCD_MAX_CYCLES
) (
  input  logic clk,
  input  logic clr_n,
  input  logic start,
  input  logic run,
  output logic expired
);

  localparam int unsigned CW = $clog2(MAX_CYCLES + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!clr_n || start) begin
      cnt <= '0;
    end else if (run && !expired) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign expired = run && (cnt == CW'(MAX_CYCLES));

endmodule

// File: rtl/gcd_sequencer.sv
// Host-side initiator for the GCD core: request/response handshakes, trivial-operand bypass.
// Optional RUN watchdog enabled by defining GCD_SEQ_TIMEOUT_EN.
module gcd_sequencer
  import gcd_pkg::*;
#(
  parameter int unsigned WIDTH      = GCD_WIDTH,
  parameter int unsigned CLR_CYCLES = GCD_CLR_CYCLES,
  parameter int unsigned MAX_CYCLES = GCD_MAX_CYCLES
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_err,
  output logic             core_clr,
  output logic [WIDTH-1:0] core_xin,
  output logic [WIDTH-1:0] core_yin,
  input  logic             core_stop,
  input  logic [WIDTH-1:0] core_gout,
  output logic             busy
);

  localparam int unsigned LCW = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
  localparam logic [LCW-1:0] LOAD_LAST = LCW'(CLR_CYCLES - 1);

  if (CLR_CYCLES < 1 || MAX_CYCLES < 1) begin : g_param_check
    $error("gcd_sequencer: CLR_CYCLES and MAX_CYCLES must be at least 1");
  end

  gcd_state_t     state, state_next;
  logic [LCW-1:0] load_cnt;
  logic           trivial;
  logic           timeout;

  // Pairs the core cannot terminate on (a zero operand) or needs no work for (a==b).
  assign trivial = (req_a == '0) || (req_b == '0) || (req_a == req_b);

`ifdef GCD_SEQ_TIMEOUT_EN
  gcd_seq_watchdog #(
    .MAX_CYCLES (MAX_CYCLES)
  ) u_watchdog (
    .clk     (clk),
    .clr_n   (clr_n),
    .start   ((state == ST_LOAD) && (state_next == ST_RUN)),
    .run     (state == ST_RUN),
    .expired (timeout)
  );
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      state <= ST_INIT;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_INIT: state_next = ST_IDLE;
      ST_IDLE: if (req_valid) state_next = trivial ? ST_RESP : ST_LOAD;
      ST_LOAD: if (load_cnt == LOAD_LAST) state_next = ST_RUN;
      ST_RUN:  if (core_stop || timeout) state_next = ST_RESP;
      ST_RESP: if (rsp_ready) state_next = ST_IDLE;
      default: state_next = ST_INIT;
    endcase
  end

  always_comb begin
    req_ready = (state == ST_IDLE);
    rsp_valid = (state == ST_RESP);
    core_clr  = (state != ST_RUN);
    busy      = (state == ST_LOAD) || (state == ST_RUN) || (state == ST_RESP);
  end

  // core_stop takes priority over watchdog expiry in the same cycle.
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      rsp_data <= '0;
      rsp_err  <= 1'b0;
      core_xin <= '0;
      core_yin <= '0;
      load_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            load_cnt <= '0;
            if (req_a == '0 && req_b == '0) begin
              rsp_data <= '0;
              rsp_err  <= 1'b1;
            end else if (req_a == '0 || req_b == '0) begin
              rsp_data <= req_a | req_b;
              rsp_err  <= 1'b0;
            end else if (req_a == req_b) begin
              rsp_data <= req_a;
              rsp_err  <= 1'b0;
            end else begin
              core_xin <= req_a;
              core_yin <= req_b;
            end
          end
        end
        ST_LOAD: load_cnt <= load_cnt + LCW'(1);
        ST_RUN: begin
          if (core_stop) begin
            rsp_data <= core_gout;
            rsp_err  <= 1'b0;
          end else if (timeout) begin
            rsp_data <= '0;
            rsp_err  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gcd_sequencer.sv
// Scoreboard bench for gcd_sequencer with a behavioural subtractive GCD core model.
module tb_gcd_sequencer;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         clr_n;
  logic         req_valid;
  logic         req_ready;
  logic [W-1:0] req_a, req_b;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_data;
  logic         rsp_err;
  logic         core_clr;
  logic [W-1:0] core_xin, core_yin;
  logic         core_stop;
  logic [W-1:0] core_gout;
  logic         busy;

  logic [W-1:0] cx, cy;
  logic         stop_tie;

  int checks = 0;
  int errors = 0;
  logic [W:0] sb[$];

  always #5 clk = ~clk;

  gcd_sequencer #(
    .WIDTH      (W),
    .CLR_CYCLES (2),
    .MAX_CYCLES (16)
  ) dut (
    .clk       (clk),
    .clr_n     (clr_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .core_clr  (core_clr),
    .core_xin  (core_xin),
    .core_yin  (core_yin),
    .core_stop (core_stop),
    .core_gout (core_gout),
    .busy      (busy)
  );

  // Subtractive GCD core: loads operands while cleared, iterates otherwise.
  always @(posedge clk) begin
    if (core_clr) begin
      cx <= core_xin;
      cy <= core_yin;
    end else if (cx > cy) begin
      cx <= cx - cy;
    end else if (cy > cx) begin
      cy <= cy - cx;
    end
  end
  assign core_stop = !stop_tie && !core_clr && (cx == cy);
  assign core_gout = cx;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (clr_n && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: got data %0h err %0b expected no response", rsp_data, rsp_err);
      end else begin
        logic [W:0] e;
        e = sb.pop_front();
        chk("rsp_data", 32'(rsp_data), 32'(e[W-1:0]));
        chk("rsp_err", 32'(rsp_err), 32'(e[W]));
      end
    end
  end

  // Called at a negedge; drives the request there, returns just after the accepting edge.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
    int n;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) chk("req_ready_wait", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_a     = a;
    req_b     = b;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int maxc, output bit ok);
    ok = 0;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk("rsp_timeout", 32'(rsp_valid), 32'd1);
  endtask

  task automatic wait_run(input int maxc, output bit ok);
    ok = 0;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (!core_clr) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk("run_timeout", 32'(core_clr), 32'd0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd0);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_rsp_data"}, 32'(rsp_data), 32'd0);
    chk({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
    chk({tag, "_core_clr"}, 32'(core_clr), 32'd1);
    chk({tag, "_core_xin"}, 32'(core_xin), 32'd0);
    chk({tag, "_core_yin"}, 32'(core_yin), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    bit ok;
    int n;
    bit saw_rsp, saw_idle;

    clr_n     = 1'b0;
    req_valid = 1'b0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    stop_tie  = 1'b0;

    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    @(posedge clk);
    #1 clr_n = 1'b1;
    @(negedge clk);
    chk("init_req_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    chk("idle_req_ready", 32'(req_ready), 32'd1);

    // (12,18) through the core
    sb.push_back({1'b0, 8'd6});
    send(8'd12, 8'd18);
    @(negedge clk);
    chk("load1_core_clr", 32'(core_clr), 32'd1);
    chk("load1_busy", 32'(busy), 32'd1);
    chk("load1_req_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    chk("load2_core_clr", 32'(core_clr), 32'd1);
    @(negedge clk);
    chk("run_core_clr", 32'(core_clr), 32'd0);
    chk("core_xin", 32'(core_xin), 32'd12);
    chk("core_yin", 32'(core_yin), 32'd18);
    wait_rsp(50, ok);
    @(negedge clk);
    chk("post_rsp_req_ready", 32'(req_ready), 32'd1);
    chk("post_rsp_valid", 32'(rsp_valid), 32'd0);

    // (0,7) and (0,0) bypass
    sb.push_back({1'b0, 8'd7});
    send(8'd0, 8'd7);
    @(negedge clk);
    chk("bypass07_valid_t1", 32'(rsp_valid), 32'd1);
    chk("bypass07_core_clr", 32'(core_clr), 32'd1);
    @(negedge clk);
    chk("bypass07_core_clr2", 32'(core_clr), 32'd1);
    chk("bypass07_req_ready", 32'(req_ready), 32'd1);
    sb.push_back({1'b1, 8'd0});
    send(8'd0, 8'd0);
    @(negedge clk);
    chk("bypass00_valid_t1", 32'(rsp_valid), 32'd1);
    @(negedge clk);

    // (9,9) bypass, then (35,21) with a stalled consumer
    sb.push_back({1'b0, 8'd9});
    send(8'd9, 8'd9);
    @(negedge clk);
    chk("bypass99_valid_t1", 32'(rsp_valid), 32'd1);
    chk("core_xin_held", 32'(core_xin), 32'd12);
    @(negedge clk);
    rsp_ready = 1'b0;
    sb.push_back({1'b0, 8'd7});
    send(8'd35, 8'd21);
    wait_rsp(50, ok);
    for (int i = 0; i < 5; i++) begin
      chk("stall_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("stall_rsp_data", 32'(rsp_data), 32'd7);
      chk("stall_req_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("stall_release_req_ready", 32'(req_ready), 32'd1);

    // reset during RUN of (48,36)
    send(8'd48, 8'd36);
    wait_run(20, ok);
    clr_n = 1'b0;
    @(posedge clk);
    #1 clr_n = 1'b1;
    @(negedge clk);
    chk_reset_vals("abort");
    repeat (4) @(negedge clk);
    sb.push_back({1'b0, 8'd12});
    send(8'd48, 8'd36);
    wait_rsp(50, ok);
    @(negedge clk);

    // (5,3) with the core never stopping
    stop_tie = 1'b1;
    send(8'd5, 8'd3);
`ifdef GCD_SEQ_TIMEOUT_EN
    sb.push_back({1'b1, 8'd0});
    wait_run(20, ok);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      n++;
      if (rsp_valid) break;
    end
    chk("timeout_latency", 32'(n), 32'd17);
    chk("timeout_core_clr", 32'(core_clr), 32'd1);
    @(negedge clk);
`else
    saw_rsp  = 0;
    saw_idle = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (rsp_valid) saw_rsp = 1;
      if (!busy) saw_idle = 1;
    end
    chk("no_timeout_rsp", 32'(saw_rsp), 32'd0);
    chk("no_timeout_busy_drop", 32'(saw_idle), 32'd0);
    clr_n = 1'b0;
    repeat (2) @(negedge clk);
    clr_n = 1'b1;
    @(negedge clk);
`endif
    stop_tie = 1'b0;

    for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
